// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt arbiter.
//   clic_cand_t  : one arbitration candidate (valid, id, level, shv flag)
//   clic_state_e : arbiter presentation state
//   clic_better  : returns the winner of two candidates (higher level, then higher id)
// The candidate struct is sized from the default constants below. A top-level build with
// different NumSrc/LvlWidth values must update these constants to match.
package clic_pkg;

  localparam int unsigned NumSrcDef   = 256;
  localparam int unsigned LvlWidthDef = 8;
  localparam int unsigned IdWidthDef  = $clog2(NumSrcDef);

  typedef struct packed {
    logic                   valid;
    logic [IdWidthDef-1:0]  id;
    logic [LvlWidthDef-1:0] lvl;
    logic                   shv;
  } clic_cand_t;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESENT = 2'd1,
    KILL    = 2'd2
  } clic_state_e;

  // Unsigned level compare; equal levels resolve to the higher id.
  function automatic clic_cand_t clic_better(input clic_cand_t a, input clic_cand_t b);
    clic_cand_t w;
    if (!a.valid) begin
      w = b;
    end else if (!b.valid) begin
      w = a;
    end else if ((a.lvl > b.lvl) || ((a.lvl == b.lvl) && (a.id > b.id))) begin
      w = a;
    end else begin
      w = b;
    end
    return w;
  endfunction

endpackage

// File: rtl/clic_chunk_max.sv
// Combinational max-tree over one chunk of interrupt sources.
//   elig_i    : per-source eligibility (already qualified by ip/ie/threshold)
//   lvl_i     : per-source level
//   shv_i     : per-source selective-hardware-vectoring flag
//   base_id_i : id of the first source in the chunk
//   win_o     : best eligible candidate (valid=0 when none is eligible)
module clic_chunk_max
  import clic_pkg::*;
#(
  parameter int unsigned ChunkSize = 32
) (
  input  logic [ChunkSize-1:0]                  elig_i,
  input  logic [ChunkSize-1:0][LvlWidthDef-1:0] lvl_i,
  input  logic [ChunkSize-1:0]                  shv_i,
  input  logic [IdWidthDef-1:0]                 base_id_i,
  output clic_cand_t                            win_o
);

  localparam int unsigned NumNodes = 2 * ChunkSize - 1;

  // Heap layout: leaves at [ChunkSize-1 .. 2*ChunkSize-2], root at 0. The compare
  // carries the id explicitly, so tree ordering does not affect the tie-break.
  clic_cand_t node [NumNodes];

  always_comb begin
    node = '{default: '0};
    for (int unsigned j = 0; j < ChunkSize; j++) begin
      node[ChunkSize-1+j].valid = elig_i[j];
      node[ChunkSize-1+j].id    = base_id_i + IdWidthDef'(j);
      node[ChunkSize-1+j].lvl   = lvl_i[j];
      node[ChunkSize-1+j].shv   = shv_i[j];
    end
    for (int i = int'(ChunkSize) - 2; i >= 0; i--) begin
      node[i] = clic_better(node[2*i+1], node[2*i+2]);
    end
  end

  assign win_o = node[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// Target-side CLIC interrupt selector. Sweeps pending/enable/level state one chunk per
// cycle, keeps a running best, and presents the winner to the core over valid/ready.
// A presented interrupt is retracted via kill_req_o/kill_ack_i when its source drops or
// a completed background sweep finds a strictly higher level.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   ip_i, ie_i, shv_i     : per-source pending, enable, shv flag
//   lvl_i                 : per-source level, source k at [k*LvlWidth +: LvlWidth]
//   thresh_i              : core threshold, sampled at chunk 0 of each sweep
//   irq_valid_o/ready_i   : presentation handshake with id/lvl/shv
//   kill_req_o/kill_ack_i : retraction handshake
//   claim_valid_o/id_o    : one-cycle pulse after an accepted interrupt
// Build option: define CLIC_SCAN_PIPE_EN to register the chunk winner before the merge
// (sweep and presentation latency grow by one cycle; drop detection stays combinational).
module clic_irq_arbiter
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc    = NumSrcDef,
  parameter int unsigned ChunkSize = 32,
  parameter int unsigned LvlWidth  = LvlWidthDef,
  parameter int unsigned IdWidth   = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumSrc-1:0]            ip_i,
  input  logic [NumSrc-1:0]            ie_i,
  input  logic [NumSrc*LvlWidth-1:0]   lvl_i,
  input  logic [NumSrc-1:0]            shv_i,
  input  logic [LvlWidth-1:0]          thresh_i,
  output logic                         irq_valid_o,
  input  logic                         irq_ready_i,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LvlWidth-1:0]          irq_lvl_o,
  output logic                         irq_shv_o,
  output logic                         kill_req_o,
  input  logic                         kill_ack_i,
  output logic                         claim_valid_o,
  output logic [IdWidth-1:0]           claim_id_o
);

  localparam int unsigned NumChunks = NumSrc / ChunkSize;
`ifdef CLIC_SCAN_PIPE_EN
  localparam int unsigned LastCnt = NumChunks;
`else
  localparam int unsigned LastCnt = NumChunks - 1;
`endif
  localparam int unsigned CntW = (LastCnt > 0) ? $clog2(LastCnt + 1) : 1;

  logic [CntW-1:0]                     cnt_q, chunk_sel;
  logic [LvlWidth-1:0]                 thresh_q, thresh_eff;
  logic [NumSrc-1:0][LvlWidth-1:0]     lvl_arr;
  logic [IdWidth-1:0]                  chunk_base;
  logic [ChunkSize-1:0][IdWidth-1:0]   chunk_idx;
  logic [ChunkSize-1:0]                chunk_elig, chunk_shv;
  logic [ChunkSize-1:0][LvlWidth-1:0]  chunk_lvl;
  clic_cand_t                          chunk_win, merge_in, best_q, best_merged;
  logic                                sweep_done, preempt, present_live, handshake, restart;

  clic_state_e          state_q;
  logic                 irq_valid_q, irq_shv_q, kill_q, claim_valid_q;
  logic [IdWidth-1:0]   irq_id_q, claim_id_q;
  logic [LvlWidth-1:0]  irq_lvl_q;

  assign lvl_arr = lvl_i;

  // Chunk 0 sees the live threshold; the rest of the sweep uses the copy taken then.
  assign thresh_eff = (cnt_q == '0) ? thresh_i : thresh_q;
  assign chunk_base = IdWidth'(ChunkSize * 32'(chunk_sel));

  always_comb begin
    chunk_idx  = '0;
    chunk_elig = '0;
    chunk_lvl  = '0;
    chunk_shv  = '0;
    for (int unsigned j = 0; j < ChunkSize; j++) begin
      chunk_idx[j] = chunk_base + IdWidth'(j);
    end
    for (int unsigned j = 0; j < ChunkSize; j++) begin
      chunk_lvl[j]  = lvl_arr[chunk_idx[j]];
      chunk_shv[j]  = shv_i[chunk_idx[j]];
      chunk_elig[j] = ip_i[chunk_idx[j]] & ie_i[chunk_idx[j]] &
                      (lvl_arr[chunk_idx[j]] > thresh_eff) &
                      (lvl_arr[chunk_idx[j]] != '0);
    end
  end

  clic_chunk_max #(
    .ChunkSize (ChunkSize)
  ) u_chunk_max (
    .elig_i    (chunk_elig),
    .lvl_i     (chunk_lvl),
    .shv_i     (chunk_shv),
    .base_id_i (chunk_base),
    .win_o     (chunk_win)
  );

  assign sweep_done   = (cnt_q == CntW'(LastCnt));
  assign best_merged  = clic_better(merge_in, best_q);
  assign present_live = ip_i[irq_id_q] & ie_i[irq_id_q];
  assign handshake    = irq_valid_q & irq_ready_i;
  // Leaving PRESENT/KILL always starts a fresh sweep from chunk 0.
  assign restart      = handshake | ((state_q == KILL) & kill_ack_i);
  assign preempt      = sweep_done & best_merged.valid & (best_merged.lvl > irq_lvl_q);

`ifdef CLIC_SCAN_PIPE_EN
  clic_cand_t pipe_q;

  // The final count value only drains the pipe; no chunk is evaluated there.
  assign chunk_sel = (cnt_q < CntW'(NumChunks)) ? cnt_q : '0;
  assign merge_in  = pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || restart || (cnt_q >= CntW'(NumChunks))) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= chunk_win;
    end
  end
`else
  assign chunk_sel = cnt_q;
  assign merge_in  = chunk_win;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      best_q   <= '0;
      thresh_q <= '0;
    end else if (restart) begin
      cnt_q  <= '0;
      best_q <= '0;
    end else begin
      if (cnt_q == '0) begin
        thresh_q <= thresh_i;
      end
      if (sweep_done) begin
        cnt_q  <= '0;
        best_q <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        best_q <= best_merged;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SCAN;
      irq_valid_q   <= 1'b0;
      irq_id_q      <= '0;
      irq_lvl_q     <= '0;
      irq_shv_q     <= 1'b0;
      kill_q        <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      claim_valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          if (sweep_done && best_merged.valid) begin
            irq_valid_q <= 1'b1;
            irq_id_q    <= best_merged.id;
            irq_lvl_q   <= best_merged.lvl;
            irq_shv_q   <= best_merged.shv;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready_i) begin
            claim_valid_q <= 1'b1;
            claim_id_q    <= irq_id_q;
            irq_valid_q   <= 1'b0;
            state_q       <= SCAN;
          end else if (!present_live || preempt) begin
            kill_q  <= 1'b1;
            state_q <= KILL;
          end
        end
        KILL: begin
          // An accept beats a simultaneous kill acknowledge.
          if (irq_ready_i) begin
            claim_valid_q <= 1'b1;
            claim_id_q    <= irq_id_q;
            irq_valid_q   <= 1'b0;
            kill_q        <= 1'b0;
            state_q       <= SCAN;
          end else if (kill_ack_i) begin
            irq_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            state_q     <= SCAN;
          end
        end
        default: begin
          irq_valid_q <= 1'b0;
          kill_q      <= 1'b0;
          state_q     <= SCAN;
        end
      endcase
    end
  end

  assign irq_valid_o   = irq_valid_q;
  assign irq_id_o      = irq_id_q;
  assign irq_lvl_o     = irq_lvl_q;
  assign irq_shv_o     = irq_shv_q;
  assign kill_req_o    = kill_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;

endmodule
